// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package adder_seq_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned calc_nslice(input int unsigned width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/adder_slice_sequencer_ripple.sv
// 4-bit combinational ripple-carry slice shared across all nibble passes.
module ripple_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       cin,
    output logic [3:0] F,
    output logic       cout
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        F    = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            F[i]   = A[i] ^ B[i] ^ c[i];
            c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
        cout = c[4];
    end

endmodule

// File: rtl/adder_slice_sequencer.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a shared ripple slice.
// Define SEQ_SIGNED_OVF_EN to add the registered two's-complement overflow output ovf.
module adder_slice_sequencer
    import adder_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NSLICE = calc_nslice(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SEQ_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W || NSLICE != WIDTH / SLICE_W) begin : g_width_chk
        $error("adder_slice_sequencer: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t             state, state_next;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic               carry_reg;
    logic [IDX_W-1:0]   idx;
    logic [SLICE_W-1:0] slice_a, slice_b, slice_f;
    logic               slice_co;
    logic               accept, step, last;

    // State register; handshake flags are registered decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (in_valid)        state_next = RUN;
            RUN:  if (idx == LAST_IDX) state_next = DONE;
            DONE: if (out_ready)       state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // Datapath control and nibble select for the shared slice.
    always_comb begin
        accept  = (state == IDLE) && in_valid;
        step    = (state == RUN);
        last    = step && (idx == LAST_IDX);
        slice_a = '0;
        slice_b = '0;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (idx == IDX_W'(i)) begin
                slice_a = a_reg[i*SLICE_W +: SLICE_W];
                slice_b = b_reg[i*SLICE_W +: SLICE_W];
            end
        end
    end

    ripple_4bit u_slice (
        .A    (slice_a),
        .B    (slice_b),
        .cin  (carry_reg),
        .F    (slice_f),
        .cout (slice_co)
    );

    // Carry register holds cin for the first pass, then the previous slice carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef SEQ_SIGNED_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            if (accept) begin
                a_reg     <= a;
                b_reg     <= b;
                carry_reg <= cin;
                idx       <= '0;
            end
            if (step) begin
                for (int unsigned i = 0; i < NSLICE; i++) begin
                    if (idx == IDX_W'(i)) begin
                        sum[i*SLICE_W +: SLICE_W] <= slice_f;
                    end
                end
                carry_reg <= slice_co;
                idx       <= idx + IDX_W'(1);
            end
            if (last) begin
                cout <= slice_co;
`ifdef SEQ_SIGNED_OVF_EN
                ovf  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (slice_f[SLICE_W-1] != a_reg[WIDTH-1]);
`endif
            end
        end
    end

endmodule
